fp16_accumulator: RTL

Sequential FP16 accumulate stage of the MAC unit, sitting directly downstream of the combinational FP16 `multiplier`. It consumes one product per valid/ready handshake and adds it to a running FP16 accumulator through a multi-cycle align/add/normalize FSM. On the term flagged `in_last`, it emits the final sum and re-arms for the next dot product.

---
 rtl/fp16_accumulator.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/fp16_accumulator.sv
// fp16_accumulator: sequential IEEE-754 binary16 accumulate stage.
// Accepts one product per handshake and adds it to the running sum through
// an ALIGN -> ADD -> NORM sequence. A term flagged last dumps the sum to
// out_data with a one-cycle out_valid and restarts the accumulation at zero.
module fp16_accumulator (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  input  logic        in_last,
  input  logic        clear,
  output logic [15:0] acc,
  output logic        out_valid,
  output logic [15:0] out_data
);

  typedef enum logic [1:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM} state_t;

  localparam logic [15:0] QNAN = 16'h7E00;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [15:0] r_acc;
  logic [15:0] r_out_data;
  logic        r_out_valid;

  logic [15:0] r_term;
  logic        r_last;

  logic [4:0]  r_big_e_p1;
  logic [10:0] r_big_m_p1;
  logic [10:0] r_sml_m_p1;
  logic        r_big_s_p1;
  logic        r_sub_p1;
  logic        r_spec_p1;
  logic [15:0] r_spec_val_p1;

  logic [11:0] r_sum_p2;
  logic [4:0]  r_sum_e_p2;
  logic        r_sum_s_p2;

  logic        w_hs;
  logic [4:0]  w_ea, w_eb;
  logic [10:0] w_ma, w_mb;
  logic        w_sa, w_sb;
  logic        w_nan_a, w_nan_b, w_inf_a, w_inf_b;
  logic        w_a_ge_b;
  logic [4:0]  w_big_e, w_sml_e, w_diff;
  logic [10:0] w_big_m, w_sml_m, w_sml_al;
  logic        w_big_s, w_sml_s;
  logic        w_spec;
  logic [15:0] w_spec_val;
  logic [15:0] w_result;

  // Normalize a 12-bit magnitude, truncate to 10 fraction bits, and saturate
  // the exponent: underflow flushes to +0, overflow becomes signed infinity.
  function automatic logic [15:0] norm_trunc(input logic s, input logic [4:0] e,
                                             input logic [11:0] sum);
    logic signed [6:0] e_s;
    logic [10:0]       m;
    logic [3:0]        lz;
    lz  = 4'd0;
    m   = 11'd0;
    e_s = 7'sd0;
    if (sum[11]) begin
      m   = sum[11:1];
      e_s = $signed({2'b00, e}) + 7'sd1;
    end else begin
      for (int i = 0; i < 11; i++) begin
        if (sum[i]) lz = 4'(10 - i);
      end
      m   = sum[10:0] << lz;
      e_s = $signed({2'b00, e}) - $signed({3'b000, lz});
    end
    if (sum == 12'd0 || e_s <= 7'sd0) return 16'h0000;
    else if (e_s >= 7'sd31)           return {s, 5'h1F, 10'h000};
    else                              return {s, e_s[4:0], m[9:0]};
  endfunction

  assign in_ready  = (r_state == S_IDLE) && !clear;
  assign w_hs      = in_valid && in_ready;
  assign acc       = r_acc;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

  // Unpack: exponent 0 (zero or subnormal) contributes a zero mantissa.
  assign w_ea    = r_acc[14:10];
  assign w_eb    = r_term[14:10];
  assign w_sa    = r_acc[15];
  assign w_sb    = r_term[15];
  assign w_ma    = (w_ea == 5'd0) ? 11'd0 : {1'b1, r_acc[9:0]};
  assign w_mb    = (w_eb == 5'd0) ? 11'd0 : {1'b1, r_term[9:0]};
  assign w_nan_a = (w_ea == 5'h1F) && (r_acc[9:0] != 10'd0);
  assign w_nan_b = (w_eb == 5'h1F) && (r_term[9:0] != 10'd0);
  assign w_inf_a = (w_ea == 5'h1F) && (r_acc[9:0] == 10'd0);
  assign w_inf_b = (w_eb == 5'h1F) && (r_term[9:0] == 10'd0);

  // Order by magnitude; exponent is compared first so big_e >= sml_e always.
  assign w_a_ge_b = {w_ea, w_ma} >= {w_eb, w_mb};
  assign w_big_e  = w_a_ge_b ? w_ea : w_eb;
  assign w_sml_e  = w_a_ge_b ? w_eb : w_ea;
  assign w_big_m  = w_a_ge_b ? w_ma : w_mb;
  assign w_sml_m  = w_a_ge_b ? w_mb : w_ma;
  assign w_big_s  = w_a_ge_b ? w_sa : w_sb;
  assign w_sml_s  = w_a_ge_b ? w_sb : w_sa;
  assign w_diff   = w_big_e - w_sml_e;
  assign w_sml_al = (w_diff >= 5'd11) ? 11'd0 : (w_sml_m >> w_diff);

  assign w_spec     = w_nan_a || w_nan_b || w_inf_a || w_inf_b;
  assign w_spec_val = (w_nan_a || w_nan_b || (w_inf_a && w_inf_b && (w_sa != w_sb))) ? QNAN :
                      w_inf_a ? r_acc : r_term;

  assign w_result = r_spec_p1 ? r_spec_val_p1 : norm_trunc(r_sum_s_p2, r_sum_e_p2, r_sum_p2);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; clear always returns to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_hs) w_state_nxt = S_ALIGN;
      S_ALIGN: w_state_nxt = S_ADD;
      S_ADD:   w_state_nxt = S_NORM;
      S_NORM:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (clear) w_state_nxt = S_IDLE;
  end

  // Datapath: capture on handshake, then ALIGN (p1) and ADD (p2) registers.
  always_ff @(posedge clk) begin
    if (w_hs) begin
      r_term <= in_data;
      r_last <= in_last;
    end
    // ALIGN -> ADD boundary
    if (r_state == S_ALIGN) begin
      r_big_e_p1    <= w_big_e;
      r_big_m_p1    <= w_big_m;
      r_sml_m_p1    <= w_sml_al;
      r_big_s_p1    <= w_big_s;
      r_sub_p1      <= w_big_s != w_sml_s;
      r_spec_p1     <= w_spec;
      r_spec_val_p1 <= w_spec_val;
    end
    // ADD -> NORM boundary
    if (r_state == S_ADD) begin
      r_sum_p2   <= r_sub_p1 ? ({1'b0, r_big_m_p1} - {1'b0, r_sml_m_p1})
                             : ({1'b0, r_big_m_p1} + {1'b0, r_sml_m_p1});
      r_sum_e_p2 <= r_big_e_p1;
      r_sum_s_p2 <= r_big_s_p1;
    end
  end

  // Accumulator and result registers: NORM writes acc or dumps a last term.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc       <= 16'h0000;
      r_out_data  <= 16'h0000;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      if (clear) begin
        r_acc <= 16'h0000;
      end else if (r_state == S_NORM) begin
        if (r_last) begin
          r_out_data  <= w_result;
          r_out_valid <= 1'b1;
          r_acc       <= 16'h0000;
        end else begin
          r_acc <= w_result;
        end
      end
    end
  end

endmodule
